commit_trace_fifo: RTL and testbench

Hardware commit-trace collector for the pipelined RV32 core. It captures every architectural commit event raised by the pipeline in one cycle, up to five per cycle: register/load write-back, store, taken or not-taken branch, jalr, and trap. It serialises these events, oldest first, into a buffered record stream with a valid/ready handshake. The golden-trace checker and on-chip trace sinks consume one record per cycle from its output.

---
 rtl/commit_trace_if.sv | 50 +++++
 rtl/commit_trace_fifo.sv | 164 ++++++++++++++++
 tb/tb_commit_trace_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_if.sv
// Commit-event inputs and record-stream outputs of the commit-trace collector.
// The slave modport is the collector's view; the master modport is the pipeline/consumer side.
interface commit_trace_if #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wb_valid, wb_is_load;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_pc, wb_instr, wb_data, wb_addr;
  logic             st_valid;
  logic [31:0]      st_pc, st_instr, st_addr, st_data;
  logic             br_valid, br_taken;
  logic [31:0]      br_pc, br_instr, br_target;
  logic             jr_valid;
  logic [31:0]      jr_pc, jr_instr, jr_target;
  logic             trap_valid;
  logic [31:0]      trap_pc, trap_instr;

  logic             out_valid, out_ready;
  logic [2:0]       out_kind;
  logic [31:0]      out_pc, out_instr, out_value, out_addr;
  logic [4:0]       out_rd;
  logic [SEQ_W-1:0] out_seq;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic             halted;

  modport master (
    output wb_valid, wb_is_load, wb_rd, wb_pc, wb_instr, wb_data, wb_addr,
           st_valid, st_pc, st_instr, st_addr, st_data,
           br_valid, br_taken, br_pc, br_instr, br_target,
           jr_valid, jr_pc, jr_instr, jr_target,
           trap_valid, trap_pc, trap_instr, out_ready,
    input  out_valid, out_kind, out_pc, out_instr, out_value, out_addr,
           out_rd, out_seq, count, overflow, drop_cnt, halted
  );

  modport slave (
    input  wb_valid, wb_is_load, wb_rd, wb_pc, wb_instr, wb_data, wb_addr,
           st_valid, st_pc, st_instr, st_addr, st_data,
           br_valid, br_taken, br_pc, br_instr, br_target,
           jr_valid, jr_pc, jr_instr, jr_target,
           trap_valid, trap_pc, trap_instr, out_ready,
    output out_valid, out_kind, out_pc, out_instr, out_value, out_addr,
           out_rd, out_seq, count, overflow, drop_cnt, halted
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit-trace collector: packs up to five commit events per cycle, oldest first,
// into a record FIFO drained one record per cycle; a cycle that does not fit is dropped whole.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  commit_trace_if.slave  bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NEV = 5;

  localparam logic [2:0] K_REG = 3'd0, K_STORE = 3'd1, K_LOAD = 3'd2, K_BR_T = 3'd3,
                         K_BR_NT = 3'd4, K_JALR = 3'd5, K_TRAP = 3'd6;

  typedef struct packed {
    logic [2:0]       kind;
    logic [4:0]       rd;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [31:0]      value;
    logic [31:0]      addr;
    logic [SEQ_W-1:0] seq;
  } rec_t;

  typedef enum logic {S_RUN, S_HALTED} state_e;

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  state_e           state_q, state_d;

  logic [NEV-1:0]   ev_valid;
  rec_t             ev_rec [NEV];
  logic [2:0]       needed;
  logic [CW-1:0]    free;
  logic             accept, pop;

  // Event slots in fixed enqueue order: WB, TRAP, STORE, BRANCH, JALR.
  always_comb begin
    for (int i = 0; i < NEV; i++) ev_rec[i] = '0;
    ev_valid = '0;

    ev_valid[0]       = bus.wb_valid && (bus.wb_rd != 5'd0);
    ev_rec[0].kind    = bus.wb_is_load ? K_LOAD : K_REG;
    ev_rec[0].rd      = bus.wb_rd;
    ev_rec[0].pc      = bus.wb_pc;
    ev_rec[0].instr   = bus.wb_instr;
    ev_rec[0].value   = bus.wb_data;
    ev_rec[0].addr    = bus.wb_is_load ? bus.wb_addr : 32'd0;

    ev_valid[1]       = bus.trap_valid;
    ev_rec[1].kind    = K_TRAP;
    ev_rec[1].pc      = bus.trap_pc;
    ev_rec[1].instr   = bus.trap_instr;

    ev_valid[2]       = bus.st_valid;
    ev_rec[2].kind    = K_STORE;
    ev_rec[2].pc      = bus.st_pc;
    ev_rec[2].instr   = bus.st_instr;
    ev_rec[2].value   = bus.st_data;
    ev_rec[2].addr    = bus.st_addr;

    ev_valid[3]       = bus.br_valid;
    ev_rec[3].kind    = bus.br_taken ? K_BR_T : K_BR_NT;
    ev_rec[3].pc      = bus.br_pc;
    ev_rec[3].instr   = bus.br_instr;
    ev_rec[3].value   = bus.br_taken ? bus.br_target : 32'd0;

    ev_valid[4]       = bus.jr_valid;
    ev_rec[4].kind    = K_JALR;
    ev_rec[4].pc      = bus.jr_pc;
    ev_rec[4].instr   = bus.jr_instr;
    ev_rec[4].value   = bus.jr_target;

    if (state_q == S_HALTED) ev_valid = '0;
  end

  always_comb begin
    logic [2:0]    off;
    logic [PW-1:0] idx;
    logic [16:0]   drop_sum;

    mem_d      = mem_q;
    needed     = '0;
    off        = '0;
    idx        = '0;
    for (int i = 0; i < NEV; i++) needed = needed + 3'(ev_valid[i]);

    // Free space is judged on the start-of-cycle count, so a same-cycle pop never makes room.
    free       = CW'(DEPTH) - count_q;
    accept     = (CW'(needed) <= free);
    pop        = (count_q != '0) && bus.out_ready;

    for (int i = 0; i < NEV; i++) begin
      if (accept && ev_valid[i]) begin
        idx            = wr_ptr_q + PW'(off);
        mem_d[idx]     = ev_rec[i];
        mem_d[idx].seq = seq_ctr_q + SEQ_W'(off);
        off            = off + 3'd1;
      end
    end

    wr_ptr_d   = accept ? wr_ptr_q + PW'(needed) : wr_ptr_q;
    seq_ctr_d  = accept ? seq_ctr_q + SEQ_W'(needed) : seq_ctr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + (accept ? CW'(needed) : CW'(0)) - CW'(pop);

    drop_sum   = {1'b0, drop_cnt_q} + 17'(needed);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (!accept) begin
      overflow_d = 1'b1;
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    state_d    = state_q;
    if (state_q == S_RUN && accept && ev_valid[1]) state_d = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_ctr_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= S_RUN;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_ctr_q  <= seq_ctr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  // Record storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_kind  = mem_q[rd_ptr_q].kind;
  assign bus.out_rd    = mem_q[rd_ptr_q].rd;
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_value = mem_q[rd_ptr_q].value;
  assign bus.out_addr  = mem_q[rd_ptr_q].addr;
  assign bus.out_seq   = mem_q[rd_ptr_q].seq;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.halted    = (state_q == S_HALTED);
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: one task per scenario, inline comparisons
// against hand-computed records, one summary line at the end.
module tb_commit_trace_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  commit_trace_if #(.DEPTH(16), .SEQ_W(16)) bus ();

  commit_trace_fifo #(.DEPTH(16), .SEQ_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events;
    bus.wb_valid = 0; bus.wb_is_load = 0; bus.wb_rd = 0; bus.wb_pc = 0; bus.wb_instr = 0;
    bus.wb_data = 0; bus.wb_addr = 0;
    bus.st_valid = 0; bus.st_pc = 0; bus.st_instr = 0; bus.st_addr = 0; bus.st_data = 0;
    bus.br_valid = 0; bus.br_taken = 0; bus.br_pc = 0; bus.br_instr = 0; bus.br_target = 0;
    bus.jr_valid = 0; bus.jr_pc = 0; bus.jr_instr = 0; bus.jr_target = 0;
    bus.trap_valid = 0; bus.trap_pc = 0; bus.trap_instr = 0;
  endtask

  task automatic do_reset;
    clear_events();
    bus.out_ready = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
    n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0h want 0", bus.overflow); end
    n_cmp++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0h want 0", bus.halted); end
    $display("test_reset done");
  endtask

  task automatic test_single_wb;
    do_reset();
    bus.out_ready = 1;
    bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'h1234; bus.wb_pc = 32'h10; bus.wb_instr = 32'h00500293;
    tick();
    clear_events();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid: got %0h want 1", bus.out_valid); end
    n_cmp++; if (bus.out_kind !== 3'd0) begin n_fail++; $display("FAIL wb_kind: got %0d want 0", bus.out_kind); end
    n_cmp++; if (bus.out_rd !== 5'd5) begin n_fail++; $display("FAIL wb_rd: got %0d want 5", bus.out_rd); end
    n_cmp++; if (bus.out_value !== 32'h1234) begin n_fail++; $display("FAIL wb_value: got %0h want 1234", bus.out_value); end
    n_cmp++; if (bus.out_pc !== 32'h10) begin n_fail++; $display("FAIL wb_pc: got %0h want 10", bus.out_pc); end
    n_cmp++; if (bus.out_instr !== 32'h00500293) begin n_fail++; $display("FAIL wb_instr: got %0h want 00500293", bus.out_instr); end
    n_cmp++; if (bus.out_addr !== 32'h0) begin n_fail++; $display("FAIL wb_addr: got %0h want 0", bus.out_addr); end
    n_cmp++; if (bus.out_seq !== 16'd0) begin n_fail++; $display("FAIL wb_seq: got %0d want 0", bus.out_seq); end
    tick();
    n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL wb_count_after_pop: got %0d want 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wb_valid_after_pop: got %0h want 0", bus.out_valid); end
    $display("test_single_wb done");
  endtask

  task automatic test_multi_event;
    do_reset();
    bus.wb_valid = 1; bus.wb_is_load = 1; bus.wb_rd = 6; bus.wb_data = 32'hAB; bus.wb_addr = 32'h100;
    bus.st_valid = 1; bus.st_addr = 32'h200; bus.st_data = 32'h55;
    bus.br_valid = 1; bus.br_taken = 1; bus.br_target = 32'h40;
    tick();
    clear_events();
    n_cmp++; if (bus.count !== 5'd3) begin n_fail++; $display("FAIL multi_count: got %0d want 3", bus.count); end
    n_cmp++; if (bus.out_kind !== 3'd2) begin n_fail++; $display("FAIL multi_load_kind: got %0d want 2", bus.out_kind); end
    n_cmp++; if (bus.out_rd !== 5'd6) begin n_fail++; $display("FAIL multi_load_rd: got %0d want 6", bus.out_rd); end
    n_cmp++; if (bus.out_value !== 32'hAB) begin n_fail++; $display("FAIL multi_load_value: got %0h want ab", bus.out_value); end
    n_cmp++; if (bus.out_addr !== 32'h100) begin n_fail++; $display("FAIL multi_load_addr: got %0h want 100", bus.out_addr); end
    n_cmp++; if (bus.out_seq !== 16'd0) begin n_fail++; $display("FAIL multi_load_seq: got %0d want 0", bus.out_seq); end
    tick();
    n_cmp++; if (bus.out_kind !== 3'd2) begin n_fail++; $display("FAIL multi_hold_kind: got %0d want 2", bus.out_kind); end
    bus.out_ready = 1;
    tick();
    n_cmp++; if (bus.out_kind !== 3'd1) begin n_fail++; $display("FAIL multi_store_kind: got %0d want 1", bus.out_kind); end
    n_cmp++; if (bus.out_value !== 32'h55) begin n_fail++; $display("FAIL multi_store_value: got %0h want 55", bus.out_value); end
    n_cmp++; if (bus.out_addr !== 32'h200) begin n_fail++; $display("FAIL multi_store_addr: got %0h want 200", bus.out_addr); end
    n_cmp++; if (bus.out_rd !== 5'd0) begin n_fail++; $display("FAIL multi_store_rd: got %0d want 0", bus.out_rd); end
    n_cmp++; if (bus.out_seq !== 16'd1) begin n_fail++; $display("FAIL multi_store_seq: got %0d want 1", bus.out_seq); end
    tick();
    n_cmp++; if (bus.out_kind !== 3'd3) begin n_fail++; $display("FAIL multi_br_kind: got %0d want 3", bus.out_kind); end
    n_cmp++; if (bus.out_value !== 32'h40) begin n_fail++; $display("FAIL multi_br_value: got %0h want 40", bus.out_value); end
    n_cmp++; if (bus.out_seq !== 16'd2) begin n_fail++; $display("FAIL multi_br_seq: got %0d want 2", bus.out_seq); end
    tick();
    n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL multi_drained: got %0d want 0", bus.count); end
    $display("test_multi_event done");
  endtask

  task automatic test_rd0_not_taken;
    do_reset();
    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hDEAD;
    bus.br_valid = 1; bus.br_taken = 0; bus.br_target = 32'h77; bus.br_pc = 32'h24;
    tick();
    clear_events();
    n_cmp++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL rd0_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_kind !== 3'd4) begin n_fail++; $display("FAIL rd0_kind: got %0d want 4", bus.out_kind); end
    n_cmp++; if (bus.out_value !== 32'h0) begin n_fail++; $display("FAIL rd0_value: got %0h want 0", bus.out_value); end
    n_cmp++; if (bus.out_pc !== 32'h24) begin n_fail++; $display("FAIL rd0_pc: got %0h want 24", bus.out_pc); end
    n_cmp++; if (bus.out_seq !== 16'd0) begin n_fail++; $display("FAIL rd0_seq: got %0d want 0", bus.out_seq); end
    $display("test_rd0_not_taken done");
  endtask

  task automatic test_all_five;
    do_reset();
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h11;
    bus.trap_valid = 1; bus.trap_pc = 32'h80;
    bus.st_valid = 1; bus.st_data = 32'h33;
    bus.br_valid = 1; bus.br_taken = 0;
    bus.jr_valid = 1; bus.jr_target = 32'h55;
    tick();
    clear_events();
    n_cmp++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL five_count: got %0d want 5", bus.count); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL five_halted: got %0h want 1", bus.halted); end
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] exp_kind;
      case (i)
        0: exp_kind = 3'd0;
        1: exp_kind = 3'd6;
        2: exp_kind = 3'd1;
        3: exp_kind = 3'd4;
        default: exp_kind = 3'd5;
      endcase
      n_cmp++; if (bus.out_kind !== exp_kind) begin n_fail++; $display("FAIL five_kind[%0d]: got %0d want %0d", i, bus.out_kind, exp_kind); end
      n_cmp++; if (bus.out_seq !== 16'(i)) begin n_fail++; $display("FAIL five_seq[%0d]: got %0d want %0d", i, bus.out_seq, i); end
      tick();
    end
    $display("test_all_five done");
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.st_valid = 1; bus.st_data = 32'(i); bus.st_addr = 32'(i);
      tick();
    end
    bus.st_valid = 1; bus.jr_valid = 1; bus.jr_target = 32'hEE;
    tick();
    clear_events();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0h want 1", bus.overflow); end
    n_cmp++; if (bus.drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 2", bus.drop_cnt); end
    n_cmp++; if (bus.count !== 5'd15) begin n_fail++; $display("FAIL ovf_count: got %0d want 15", bus.count); end
    bus.jr_valid = 1; bus.jr_target = 32'h99;
    tick();
    clear_events();
    n_cmp++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 16", bus.count); end
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.out_seq !== 16'(i)) begin n_fail++; $display("FAIL ovf_drain_seq[%0d]: got %0d want %0d", i, bus.out_seq, i); end
      if (i == 15) begin
        n_cmp++; if (bus.out_kind !== 3'd5) begin n_fail++; $display("FAIL ovf_last_kind: got %0d want 5", bus.out_kind); end
        n_cmp++; if (bus.out_value !== 32'h99) begin n_fail++; $display("FAIL ovf_last_value: got %0h want 99", bus.out_value); end
      end else begin
        n_cmp++; if (bus.out_value !== 32'(i)) begin n_fail++; $display("FAIL ovf_drain_value[%0d]: got %0h want %0h", i, bus.out_value, i); end
      end
      tick();
    end
    n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", bus.count); end
    $display("test_overflow done");
  endtask

  task automatic test_full_pop_same_cycle;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.st_valid = 1; bus.st_data = 32'(i);
      tick();
    end
    clear_events();
    n_cmp++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", bus.count); end
    bus.out_ready = 1; bus.trap_valid = 1; bus.trap_pc = 32'h80;
    tick();
    clear_events();
    bus.out_ready = 0;
    n_cmp++; if (bus.count !== 5'd15) begin n_fail++; $display("FAIL full_pop_count: got %0d want 15", bus.count); end
    n_cmp++; if (bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL full_pop_drop: got %0d want 1", bus.drop_cnt); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL full_pop_overflow: got %0h want 1", bus.overflow); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL full_pop_halted: got %0h want 0", bus.halted); end
    n_cmp++; if (bus.out_value !== 32'd1) begin n_fail++; $display("FAIL full_pop_head: got %0h want 1", bus.out_value); end
    $display("test_full_pop_same_cycle done");
  endtask

  task automatic test_drop_saturate;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.jr_valid = 1;
      tick();
    end
    bus.wb_valid = 1; bus.wb_rd = 3; bus.trap_valid = 1; bus.st_valid = 1; bus.br_valid = 1; bus.jr_valid = 1;
    tick();
    n_cmp++; if (bus.drop_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_first: got %0d want 5", bus.drop_cnt); end
    for (int i = 1; i < 13107; i++) tick();
    n_cmp++; if (bus.drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_exact: got %0h want ffff", bus.drop_cnt); end
    tick();
    clear_events();
    n_cmp++; if (bus.drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h want ffff", bus.drop_cnt); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL sat_halted: got %0h want 0", bus.halted); end
    $display("test_drop_saturate done");
  endtask

  task automatic test_trap_halt;
    do_reset();
    bus.trap_valid = 1; bus.trap_pc = 32'h80; bus.trap_instr = 32'h00000073;
    tick();
    clear_events();
    n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL trap_halted: got %0h want 1", bus.halted); end
    n_cmp++; if (bus.out_kind !== 3'd6) begin n_fail++; $display("FAIL trap_kind: got %0d want 6", bus.out_kind); end
    n_cmp++; if (bus.out_pc !== 32'h80) begin n_fail++; $display("FAIL trap_pc: got %0h want 80", bus.out_pc); end
    n_cmp++; if (bus.out_value !== 32'h0) begin n_fail++; $display("FAIL trap_value: got %0h want 0", bus.out_value); end
    bus.wb_valid = 1; bus.wb_rd = 7; bus.wb_data = 32'h77;
    tick();
    clear_events();
    n_cmp++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL trap_ignore_count: got %0d want 1", bus.count); end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL trap_drain: got %0d want 0", bus.count); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL trap_sticky: got %0h want 1", bus.halted); end
    bus.wb_valid = 1; bus.wb_rd = 7;
    reset_n = 0;
    tick();
    reset_n = 1;
    clear_events();
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL trap_reset_halted: got %0h want 0", bus.halted); end
    n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL trap_reset_count: got %0d want 0", bus.count); end
    bus.wb_valid = 1; bus.wb_rd = 8; bus.wb_data = 32'h88;
    tick();
    clear_events();
    n_cmp++; if (bus.out_seq !== 16'd0) begin n_fail++; $display("FAIL trap_reset_seq: got %0d want 0", bus.out_seq); end
    n_cmp++; if (bus.out_value !== 32'h88) begin n_fail++; $display("FAIL trap_reset_value: got %0h want 88", bus.out_value); end
    $display("test_trap_halt done");
  endtask

  initial begin
    clear_events();
    bus.out_ready = 0;
    test_reset();
    test_single_wb();
    test_multi_event();
    test_rd0_not_taken();
    test_all_five();
    test_overflow();
    test_full_pop_same_cycle();
    test_drop_saturate();
    test_trap_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
